// File: rtl/vga_timing_decoder_pkg.sv
// Shared constants for the VGA timing decoder: lock-state encodings, default
// counter width and the 640x480 reference geometry.
package vga_timing_decoder_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_VERIFY  = 2'd2,
    ST_LOCKED  = 2'd3
  } lock_state_e;

  localparam int DEF_CW = 12;

  localparam int REF_H_TOTAL  = 800;
  localparam int REF_H_ACTIVE = 640;
  localparam int REF_V_TOTAL  = 525;
  localparam int REF_V_ACTIVE = 480;

endpackage

// File: rtl/vga_sync_edge.sv
// Normalises a sync/qualifier input to active-high, registers it twice and
// reports assertion and deassertion edges of the registered level.
module vga_sync_edge #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_i,
  output logic level_o,
  output logic assert_o,
  output logic deassert_o
);

  logic s1_q;
  logic s2_q;

  // Two-stage capture; reset value is the deasserted level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= (sync_i == POL);
      s2_q <= s1_q;
    end
  end

  assign level_o    = s1_q;
  assign assert_o   = s1_q & ~s2_q;
  assign deassert_o = ~s1_q & s2_q;

endmodule

// File: rtl/vga_timing_decoder.sv
// Recovers pixel coordinates, line/frame geometry and a lock indication from
// a VGA-timed hsync/vsync/data_enable stream.
module vga_timing_decoder
  import vga_timing_decoder_pkg::*;
#(
  parameter int CW        = DEF_CW,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int TIMEOUT   = 4095
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          data_enable,
  output logic          pix_valid,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic          locked,
  output logic          timing_err,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active
);

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] TO_LIM    = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LIM_M1 = CW'(TIMEOUT - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + ONE;
  endfunction

  logic hs_lvl_s, hs_rise_s, hs_fall_s;
  logic vs_lvl_s, vs_rise_s, vs_fall_s;
  logic de_lvl_s, de_rise_s, de_fall_s;
  logic sync_unused_s;

  vga_sync_edge #(.POL(HSYNC_POL)) u_hs (
    .clk(clk), .rst(rst), .sync_i(hsync),
    .level_o(hs_lvl_s), .assert_o(hs_rise_s), .deassert_o(hs_fall_s)
  );
  vga_sync_edge #(.POL(VSYNC_POL)) u_vs (
    .clk(clk), .rst(rst), .sync_i(vsync),
    .level_o(vs_lvl_s), .assert_o(vs_rise_s), .deassert_o(vs_fall_s)
  );
  vga_sync_edge #(.POL(1'b1)) u_de (
    .clk(clk), .rst(rst), .sync_i(data_enable),
    .level_o(de_lvl_s), .assert_o(de_rise_s), .deassert_o(de_fall_s)
  );

  assign sync_unused_s = ^{hs_lvl_s, hs_fall_s, vs_lvl_s, vs_fall_s};

  logic          pix_valid_q, pix_valid_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          frame_start_q, frame_start_d;
  logic          locked_q, locked_d;
  logic          timing_err_q, timing_err_d;
  logic [CW-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [CW-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d, a_cnt_q, a_cnt_d;
  logic [CW-1:0] l_cnt_q, l_cnt_d, r_cnt_q, r_cnt_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic [CW-1:0] ha_first_q, ha_first_d;
  logic          first_line_q, first_line_d;
  logic [CW-1:0] ref_ht_q, ref_ht_d, ref_ha_q, ref_ha_d;
  logic [CW-1:0] ref_vt_q, ref_vt_d, ref_va_q, ref_va_d;
  lock_state_e   state_q, state_d;
  logic          timeout_s;
  logic          match_all_s;
  logic          h_bad_s;
  logic          v_bad_s;

  // Coordinate, measurement and timeout counters.
  always_comb begin
    pix_valid_d   = de_lvl_s;
    frame_start_d = vs_rise_s;

    if (de_rise_s)     x_d = '0;
    else if (de_lvl_s) x_d = sat_inc(x_q);
    else               x_d = x_q;

    if (vs_rise_s)      y_d = '0;
    else if (de_fall_s) y_d = sat_inc(y_q);
    else                y_d = y_q;

    // h_cnt counts the edge clock itself, so it equals the period at the next edge.
    if (hs_rise_s) begin
      h_cnt_d   = ONE;
      h_total_d = h_cnt_q;
    end else begin
      h_cnt_d   = sat_inc(h_cnt_q);
      h_total_d = h_total_q;
    end

    if (de_rise_s)     a_cnt_d = ONE;
    else if (de_lvl_s) a_cnt_d = sat_inc(a_cnt_q);
    else               a_cnt_d = a_cnt_q;

    h_active_d = de_fall_s ? a_cnt_q : h_active_q;

    if (vs_rise_s)      first_line_d = 1'b1;
    else if (de_fall_s) first_line_d = 1'b0;
    else                first_line_d = first_line_q;

    ha_first_d = (de_fall_s && first_line_q) ? a_cnt_q : ha_first_q;

    // A concurrent hsync edge belongs to the new frame, not the one being closed.
    if (vs_rise_s) begin
      l_cnt_d    = hs_rise_s ? ONE : '0;
      r_cnt_d    = de_rise_s ? ONE : '0;
      v_total_d  = l_cnt_q;
      v_active_d = r_cnt_q;
    end else begin
      l_cnt_d    = hs_rise_s ? sat_inc(l_cnt_q) : l_cnt_q;
      r_cnt_d    = de_rise_s ? sat_inc(r_cnt_q) : r_cnt_q;
      v_total_d  = v_total_q;
      v_active_d = v_active_q;
    end

    if (hs_rise_s)               to_cnt_d = '0;
    else if (to_cnt_q != TO_LIM) to_cnt_d = to_cnt_q + ONE;
    else                         to_cnt_d = to_cnt_q;

    timeout_s = !hs_rise_s && (to_cnt_q == TO_LIM_M1);
  end

  // Lock FSM: next state, reference capture, locked and error pulse.
  always_comb begin
    state_d      = state_q;
    locked_d     = locked_q;
    timing_err_d = 1'b0;
    ref_ht_d     = ref_ht_q;
    ref_ha_d     = ref_ha_q;
    ref_vt_d     = ref_vt_q;
    ref_va_d     = ref_va_q;

    match_all_s = (h_total_d == ref_ht_q) && (ha_first_d == ref_ha_q) &&
                  (v_total_d == ref_vt_q) && (v_active_d == ref_va_q);
    h_bad_s = (hs_rise_s && (h_total_d != ref_ht_q)) ||
              (de_fall_s && (h_active_d != ref_ha_q));
    v_bad_s = vs_rise_s && ((v_total_d != ref_vt_q) || (v_active_d != ref_va_q));

    if (timeout_s) begin
      state_d      = ST_SEARCH;
      locked_d     = 1'b0;
      timing_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (vs_rise_s) state_d = ST_MEASURE;
          else           state_d = ST_SEARCH;
        end
        ST_MEASURE: begin
          if (vs_rise_s) begin
            state_d  = ST_VERIFY;
            ref_ht_d = h_total_d;
            ref_ha_d = ha_first_d;
            ref_vt_d = v_total_d;
            ref_va_d = v_active_d;
          end else begin
            state_d = ST_MEASURE;
          end
        end
        ST_VERIFY: begin
          if (vs_rise_s && match_all_s) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
          end else if (vs_rise_s) begin
            ref_ht_d = h_total_d;
            ref_ha_d = ha_first_d;
            ref_vt_d = v_total_d;
            ref_va_d = v_active_d;
          end else begin
            state_d = ST_VERIFY;
          end
        end
        ST_LOCKED: begin
          if (h_bad_s || v_bad_s) begin
            state_d      = ST_VERIFY;
            locked_d     = 1'b0;
            timing_err_d = 1'b1;
            ref_ht_d     = h_total_d;
            ref_ha_d     = ha_first_d;
            ref_vt_d     = v_total_d;
            ref_va_d     = v_active_d;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_valid_q   <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
      h_total_q     <= '0;
      h_active_q    <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
      h_cnt_q       <= '0;
      a_cnt_q       <= '0;
      l_cnt_q       <= '0;
      r_cnt_q       <= '0;
      to_cnt_q      <= '0;
      ha_first_q    <= '0;
      first_line_q  <= 1'b0;
      ref_ht_q      <= '0;
      ref_ha_q      <= '0;
      ref_vt_q      <= '0;
      ref_va_q      <= '0;
      state_q       <= ST_SEARCH;
    end else begin
      pix_valid_q   <= pix_valid_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      timing_err_q  <= timing_err_d;
      h_total_q     <= h_total_d;
      h_active_q    <= h_active_d;
      v_total_q     <= v_total_d;
      v_active_q    <= v_active_d;
      h_cnt_q       <= h_cnt_d;
      a_cnt_q       <= a_cnt_d;
      l_cnt_q       <= l_cnt_d;
      r_cnt_q       <= r_cnt_d;
      to_cnt_q      <= to_cnt_d;
      ha_first_q    <= ha_first_d;
      first_line_q  <= first_line_d;
      ref_ht_q      <= ref_ht_d;
      ref_ha_q      <= ref_ha_d;
      ref_vt_q      <= ref_vt_d;
      ref_va_q      <= ref_va_d;
      state_q       <= state_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign timing_err  = timing_err_q;
  assign h_total     = h_total_q;
  assign h_active    = h_active_q;
  assign v_total     = v_total_q;
  assign v_active    = v_active_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Self-checking bench: a scaled-down VGA stream (40x12 total, 32x8 active)
// drives an active-low decoder and an active-high-polarity twin.
module tb_vga_timing_decoder;
  import vga_timing_decoder_pkg::*;

  localparam int CW = DEF_CW;
  localparam int H  = 40;
  localparam int HA = 32;
  localparam int V  = 12;
  localparam int VA = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hs_act = 1'b0;
  logic vs_act = 1'b0;
  logic de = 1'b0;
  logic hs_n, vs_n;
  assign hs_n = ~hs_act;
  assign vs_n = ~vs_act;

  logic pv1, fs1, lk1, er1, pv2, fs2, lk2, er2;
  logic [CW-1:0] x1, y1, ht1, ha1, vt1, va1;
  logic [CW-1:0] x2, y2, ht2, ha2, vt2, va2;

  always #5 clk = ~clk;

  vga_timing_decoder #(.CW(CW), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .TIMEOUT(4095)) dut (
    .clk(clk), .rst(rst), .hsync(hs_n), .vsync(vs_n), .data_enable(de),
    .pix_valid(pv1), .x(x1), .y(y1), .frame_start(fs1), .locked(lk1), .timing_err(er1),
    .h_total(ht1), .h_active(ha1), .v_total(vt1), .v_active(va1)
  );

  vga_timing_decoder #(.CW(CW), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .TIMEOUT(4095)) dut_pos (
    .clk(clk), .rst(rst), .hsync(hs_act), .vsync(vs_act), .data_enable(de),
    .pix_valid(pv2), .x(x2), .y(y2), .frame_start(fs2), .locked(lk2), .timing_err(er2),
    .h_total(ht2), .h_active(ha2), .v_total(vt2), .v_active(va2)
  );

  int passed = 0;
  int total  = 0;

  logic [2*CW-1:0] sbq[$];
  int sb_err = 0;
  int err_n1, err_n2, fs_n1, fs_n2, lock_fs1, lock_fs2, err_fs1;
  logic lk_at_err1, lk1_prev, lk2_prev, got_first;
  int pix_cnt, frame_pix;
  logic [CW-1:0] first_x, first_y, last_x, last_y;
  logic [CW-1:0] fr_first_x, fr_first_y, fr_last_x, fr_last_y;

  // Monitor: pops expected coordinates and tracks strobes, sampled mid-cycle.
  initial begin
    logic [2*CW-1:0] exp_v;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sbq.delete();
        err_n1 = 0; err_n2 = 0; fs_n1 = 0; fs_n2 = 0;
        lock_fs1 = -1; lock_fs2 = -1; err_fs1 = -1;
        lk_at_err1 = 1'b1; lk1_prev = 1'b0; lk2_prev = 1'b0;
        pix_cnt = 0; frame_pix = 0; got_first = 1'b0;
      end else begin
        if (fs1) begin
          fs_n1++;
          frame_pix = pix_cnt; pix_cnt = 0;
          fr_first_x = first_x; fr_first_y = first_y;
          fr_last_x = last_x; fr_last_y = last_y;
          got_first = 1'b0;
        end
        if (fs2) fs_n2++;
        if (lk1 && !lk1_prev) lock_fs1 = fs_n1;
        if (lk2 && !lk2_prev) lock_fs2 = fs_n2;
        lk1_prev = lk1;
        lk2_prev = lk2;
        if (er1) begin err_n1++; err_fs1 = fs_n1; lk_at_err1 = lk1; end
        if (er2) err_n2++;
        if (pv1 || pv2) begin
          if (sbq.size() == 0) begin
            sb_err++;
            if (sb_err <= 10) $display("FAIL pix_extra got pv=%0b/%0b x=%0d y=%0d want no pixel", pv1, pv2, x1, y1);
          end else begin
            exp_v = sbq.pop_front();
            if (sb_err < 10 && {pv1, pv2, x1, y1, x2, y2} !== {2'b11, exp_v, exp_v}) begin
              sb_err++;
              $display("FAIL pix got pv=%0b/%0b x=%0d y=%0d x2=%0d y2=%0d want x=%0d y=%0d",
                       pv1, pv2, x1, y1, x2, y2, exp_v[2*CW-1:CW], exp_v[CW-1:0]);
            end
          end
          if (pv1) begin
            if (!got_first) begin first_x = x1; first_y = y1; got_first = 1'b1; end
            last_x = x1; last_y = y1;
            pix_cnt++;
          end
        end
      end
    end
  end

  task automatic drive_frame(input int stretch_row, input int stop_at);
    int n = 0;
    int len;
    for (int row = 0; row < V; row++) begin
      len = (row == stretch_row) ? H + 1 : H;
      for (int col = 0; col < len; col++) begin
        @(posedge clk); #1;
        if (stop_at >= 0 && n == stop_at) return;
        de     = (row < VA) && (col < HA);
        hs_act = (col >= HA + 2) && (col < HA + 6);
        vs_act = (row == VA + 1 && col >= HA + 2) || (row == VA + 2) ||
                 (row == VA + 3 && col < HA + 2);
        if (de) sbq.push_back({CW'(col), CW'(row)});
        n++;
      end
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      de = 1'b0; hs_act = 1'b0; vs_act = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({pv1, fs1, lk1, er1} !== 4'b0) $display("FAIL reset_strobes got=%b want=0000", {pv1, fs1, lk1, er1}); else passed++;
    total++; if ({x1, y1} !== '0) $display("FAIL reset_xy got x=%0d y=%0d want 0 0", x1, y1); else passed++;
    total++; if ({ht1, ha1, vt1, va1} !== '0) $display("FAIL reset_meas got %0d %0d %0d %0d want 0", ht1, ha1, vt1, va1); else passed++;
    total++; if ({pv2, fs2, lk2, er2, x2, y2} !== '0) $display("FAIL reset_pos got=%h want 0", {pv2, fs2, lk2, er2, x2, y2}); else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_lock();
    repeat (5) drive_frame(-1, -1);
    @(negedge clk);
    total++; if (lock_fs1 !== 3) $display("FAIL lock_frame got=%0d want=3", lock_fs1); else passed++;
    total++; if (lk1 !== 1'b1) $display("FAIL locked got=%0b want=1", lk1); else passed++;
    total++; if (ht1 !== CW'(H)) $display("FAIL h_total got=%0d want=%0d", ht1, H); else passed++;
    total++; if (ha1 !== CW'(HA)) $display("FAIL h_active got=%0d want=%0d", ha1, HA); else passed++;
    total++; if (vt1 !== CW'(V)) $display("FAIL v_total got=%0d want=%0d", vt1, V); else passed++;
    total++; if (va1 !== CW'(VA)) $display("FAIL v_active got=%0d want=%0d", va1, VA); else passed++;
    total++; if (err_n1 !== 0) $display("FAIL lock_no_err got=%0d want=0", err_n1); else passed++;
  endtask

  task automatic test_coords();
    repeat (2) drive_frame(-1, -1);
    @(negedge clk);
    total++; if (frame_pix !== HA * VA) $display("FAIL pix_per_frame got=%0d want=%0d", frame_pix, HA * VA); else passed++;
    total++; if ({fr_first_x, fr_first_y} !== '0) $display("FAIL first_pix got x=%0d y=%0d want 0 0", fr_first_x, fr_first_y); else passed++;
    total++; if (fr_last_x !== CW'(HA - 1)) $display("FAIL last_x got=%0d want=%0d", fr_last_x, HA - 1); else passed++;
    total++; if (fr_last_y !== CW'(VA - 1)) $display("FAIL last_y got=%0d want=%0d", fr_last_y, VA - 1); else passed++;
    total++; if (sb_err !== 0) $display("FAIL pix_scoreboard got=%0d errors want=0", sb_err); else passed++;
  endtask

  task automatic test_stretch();
    int e0;
    e0 = err_n1;
    drive_frame(3, -1);
    repeat (2) drive_frame(-1, -1);
    @(negedge clk);
    total++; if (err_n1 - e0 !== 1) $display("FAIL stretch_err_pulses got=%0d want=1", err_n1 - e0); else passed++;
    total++; if (lk_at_err1 !== 1'b0) $display("FAIL stretch_unlock got=%0b want=0", lk_at_err1); else passed++;
    total++; if (lock_fs1 - err_fs1 !== 2) $display("FAIL stretch_relock got=%0d frames want=2", lock_fs1 - err_fs1); else passed++;
    total++; if (lk1 !== 1'b1) $display("FAIL stretch_locked got=%0b want=1", lk1); else passed++;
  endtask

  task automatic test_timeout();
    int e0, e2;
    e0 = err_n1;
    e2 = err_n2;
    idle(4000);
    @(negedge clk);
    total++; if (err_n1 - e0 !== 0) $display("FAIL timeout_early got=%0d want=0", err_n1 - e0); else passed++;
    idle(500);
    @(negedge clk);
    total++; if (err_n1 - e0 !== 1) $display("FAIL timeout_pulses got=%0d want=1", err_n1 - e0); else passed++;
    total++; if (lk1 !== 1'b0) $display("FAIL timeout_unlock got=%0b want=0", lk1); else passed++;
    total++; if (err_n2 - e2 !== 1) $display("FAIL timeout_pos got=%0d want=1", err_n2 - e2); else passed++;
    repeat (5) drive_frame(-1, -1);
    @(negedge clk);
    total++; if (lock_fs1 - err_fs1 !== 3) $display("FAIL timeout_relock got=%0d frames want=3", lock_fs1 - err_fs1); else passed++;
    total++; if ({lk1, err_n1 - e0} !== {1'b1, 32'sd1}) $display("FAIL timeout_final got lk=%0b errs=%0d want 1 1", lk1, err_n1 - e0); else passed++;
  endtask

  task automatic test_reset_mid();
    drive_frame(-1, 2 * H + 20);
    #2 rst = 1'b0;
    #1;
    total++; if ({pv1, fs1, lk1, er1, x1, y1} !== '0) $display("FAIL rst_mid_pix got=%h want 0", {pv1, fs1, lk1, er1, x1, y1}); else passed++;
    total++; if ({ht1, ha1, vt1, va1} !== '0) $display("FAIL rst_mid_meas got %0d %0d %0d %0d want 0", ht1, ha1, vt1, va1); else passed++;
    total++; if ({lk2, ht2, ha2, vt2, va2} !== '0) $display("FAIL rst_mid_pos got=%h want 0", {lk2, ht2, ha2, vt2, va2}); else passed++;
    de = 1'b0; hs_act = 1'b0; vs_act = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) drive_frame(-1, -1);
    @(negedge clk);
    total++; if (lock_fs1 !== 3) $display("FAIL rst_relock got=%0d want=3", lock_fs1); else passed++;
    total++; if ({ht1, ha1, vt1, va1} !== {CW'(H), CW'(HA), CW'(V), CW'(VA)}) $display("FAIL rst_meas got %0d %0d %0d %0d want %0d %0d %0d %0d", ht1, ha1, vt1, va1, H, HA, V, VA); else passed++;
    total++; if (err_n1 !== 0) $display("FAIL rst_no_err got=%0d want=0", err_n1); else passed++;
  endtask

  task automatic test_polarity();
    total++; if (lock_fs2 !== 3) $display("FAIL pol_lock_frame got=%0d want=3", lock_fs2); else passed++;
    total++; if (lk2 !== 1'b1) $display("FAIL pol_locked got=%0b want=1", lk2); else passed++;
    total++; if ({ht2, ha2, vt2, va2} !== {CW'(H), CW'(HA), CW'(V), CW'(VA)}) $display("FAIL pol_meas got %0d %0d %0d %0d want %0d %0d %0d %0d", ht2, ha2, vt2, va2, H, HA, V, VA); else passed++;
    total++; if (err_n2 !== 0) $display("FAIL pol_no_err got=%0d want=0", err_n2); else passed++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_coords();
    test_stretch();
    test_timeout();
    test_reset_mid();
    test_polarity();
    idle(10);
    @(negedge clk);
    total++; if (sbq.size() !== 0) $display("FAIL pix_leftover got=%0d want=0", sbq.size()); else passed++;
    total++; if (sb_err !== 0) $display("FAIL pix_total_err got=%0d want=0", sb_err); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
